// File: rtl/soc_bridge_pkg.sv
// rtl/soc_bridge_pkg.sv - peripheral address map and hex-to-segment table for soc_bridge
package soc_bridge_pkg;

    localparam logic [19:0] PERIPH_BASE    = 20'hFFFFF;

    localparam logic [11:0] ADDR_DIG       = 12'h000;
    localparam logic [11:0] ADDR_TIMER_CNT = 12'h020;
    localparam logic [11:0] ADDR_TIMER_DIV = 12'h024;
    localparam logic [11:0] ADDR_LED       = 12'h060;
    localparam logic [11:0] ADDR_SW        = 12'h070;
    localparam logic [11:0] ADDR_BTN       = 12'h078;

    // Active-low {dp,g,f,e,d,c,b,a}, entry 0 at the low end, dp always off
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Registers are word-sized; the byte lane bits do not take part in the match
    function automatic logic addr_hit(input logic [11:0] off, input logic [11:0] reg_off);
        return off[11:2] == reg_off[11:2];
    endfunction

endpackage

// File: rtl/soc_bridge_if.sv
// rtl/soc_bridge_if.sv - CPU data-bus port between the pipeline MEM stage and soc_bridge
interface soc_bridge_if;
    logic [31:0] Bus_addr;
    logic        Bus_we;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    modport master (output Bus_addr, output Bus_we, output Bus_wdata, input  Bus_rdata);
    modport slave  (input  Bus_addr, input  Bus_we, input  Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/soc_bridge_seg_scan.sv
// rtl/soc_bridge_seg_scan.sv - multiplexed 8-digit 7-segment scanner with registered outputs
module seg_scan
    import soc_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_cnt;
    logic [2:0]    idx;

    // Outputs follow the current idx one edge later, so a DIG write lands by the next edge
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            dig_en   <= 8'hFF;
            seg      <= 8'hFF;
        end else begin
            if (scan_cnt == LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            dig_en <= ~(8'd1 << idx);
            seg    <= SEG_LUT[dig[{idx, 2'b00} +: 4]];
        end
    end

endmodule

// File: rtl/soc_bridge.sv
// rtl/soc_bridge.sv - CPU data-bus bridge to DRAM and board peripherals; timer built when BRIDGE_TIMER_EN is defined
module soc_bridge
    import soc_bridge_pkg::*;
#(
    parameter int          SCAN_DIV      = 50000,
    parameter logic [31:0] TIMER_DIV_RST = 32'd25000000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    soc_bridge_if.slave        bus,
    output logic [13:0]        dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);

    logic        periph;
    logic [11:0] off;
    logic        wr_periph;
    logic        sel_dig, sel_led, sel_sw, sel_btn;
    logic [31:0] dig_reg;
    logic [23:0] sw_s1, sw_s2;
    logic [4:0]  btn_s1, btn_s2;
    logic        unused_byte_lane;

    assign periph           = bus.Bus_addr[31:12] == PERIPH_BASE;
    assign off              = bus.Bus_addr[11:0];
    assign wr_periph        = bus.Bus_we & periph;
    assign unused_byte_lane = &{1'b0, bus.Bus_addr[1:0]};

    assign sel_dig = addr_hit(off, ADDR_DIG);
    assign sel_led = addr_hit(off, ADDR_LED);
    assign sel_sw  = addr_hit(off, ADDR_SW);
    assign sel_btn = addr_hit(off, ADDR_BTN);

    assign dram_addr  = bus.Bus_addr[15:2];
    assign dram_we    = bus.Bus_we & ~periph;
    assign dram_wdata = bus.Bus_wdata;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            dig_reg <= '0;
            led     <= '0;
        end else begin
            if (wr_periph && sel_dig) dig_reg <= bus.Bus_wdata;
            if (wr_periph && sel_led) led     <= bus.Bus_wdata[23:0];
        end
    end

    // Board inputs are asynchronous to cpu_clk
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

`ifdef BRIDGE_TIMER_EN
    logic        sel_cnt, sel_div;
    logic [31:0] timer_cnt, timer_div, presc;
    logic        timer_tick;

    assign sel_cnt    = addr_hit(off, ADDR_TIMER_CNT);
    assign sel_div    = addr_hit(off, ADDR_TIMER_DIV);
    assign timer_tick = (timer_div != 32'd0) && (presc == timer_div - 32'd1);

    // A bus write to the counter overrides a coincident increment
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            timer_cnt <= '0;
            timer_div <= TIMER_DIV_RST;
            presc     <= '0;
        end else begin
            if (wr_periph && sel_div) begin
                timer_div <= bus.Bus_wdata;
                presc     <= '0;
            end else if (timer_div != 32'd0) begin
                presc <= timer_tick ? 32'd0 : presc + 32'd1;
            end
            if (wr_periph && sel_cnt)
                timer_cnt <= bus.Bus_wdata;
            else if (timer_tick)
                timer_cnt <= timer_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        bus.Bus_rdata = 32'd0;
        if (!periph) begin
            bus.Bus_rdata = dram_rdata;
        end else begin
            if (sel_dig) bus.Bus_rdata = dig_reg;
            if (sel_led) bus.Bus_rdata = {8'd0, led};
            if (sel_sw)  bus.Bus_rdata = {8'd0, sw_s2};
            if (sel_btn) bus.Bus_rdata = {27'd0, btn_s2};
`ifdef BRIDGE_TIMER_EN
            if (sel_cnt) bus.Bus_rdata = timer_cnt;
            if (sel_div) bus.Bus_rdata = timer_div;
`endif
        end
    end

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .dig     (dig_reg),
        .dig_en  (dig_en),
        .seg     (seg)
    );

endmodule

// File: tb/tb_soc_bridge.sv
// tb/tb_soc_bridge.sv - directed self-checking bench for soc_bridge
module tb_soc_bridge;

    localparam int          SCAN_DIV = 4;
    localparam logic [31:0] TDIV_RST = 32'd25000000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int errors = 0;
    int checks = 0;

    logic [7:0] seg_exp [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] en_exp  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [31:0] cnt_exp [8] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2};

    always #5 cpu_clk = ~cpu_clk;

    soc_bridge_if bus ();

    soc_bridge #(
        .SCAN_DIV      (SCAN_DIV),
        .TIMER_DIV_RST (TDIV_RST)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .bus        (bus),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .dig_en     (dig_en),
        .seg        (seg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        bus.Bus_addr  = addr;
        bus.Bus_we    = we;
        bus.Bus_wdata = wdata;
    endtask

    initial begin
        cpu_rst    = 1'b1;
        sw         = '0;
        btn        = '0;
        dram_rdata = 32'h0;
        set_bus(32'hFFFFF060, 1'b0, 32'h0);
        repeat (2) @(posedge cpu_clk);
        #3;
        check("rst_dig_en", {24'd0, dig_en}, 32'h0000_00FF);
        check("rst_seg", {24'd0, seg}, 32'h0000_00FF);
        check("rst_led", {8'd0, led}, 32'h0);
        check("rst_led_rd", bus.Bus_rdata, 32'h0);

        // Release reset between edges and write DIG at the first edge
        cpu_rst = 1'b0;
        set_bus(32'hFFFFF000, 1'b1, 32'h76543210);
        for (int n = 0; n < 33; n++) begin
            tick();
            if (n == 0) set_bus(32'hFFFFF000, 1'b0, 32'h0);
            check($sformatf("scan_en_%0d", n), {24'd0, dig_en}, {24'd0, en_exp[(n / 4) % 8]});
            check($sformatf("scan_seg_%0d", n), {24'd0, seg}, {24'd0, seg_exp[(n / 4) % 8]});
        end
        check("dig_rd", bus.Bus_rdata, 32'h76543210);

        // LED write
        set_bus(32'hFFFFF060, 1'b1, 32'h00ABCDEF);
        #1;
        check("led_wr_dram_we", {31'd0, dram_we}, 32'h0);
        tick();
        check("led_out", {8'd0, led}, 32'h00ABCDEF);
        set_bus(32'hFFFFF060, 1'b0, 32'h0);
        #1;
        check("led_rd", bus.Bus_rdata, 32'h00ABCDEF);
        check("led_rd_dram_we", {31'd0, dram_we}, 32'h0);

        // DRAM write and read
        set_bus(32'h00000010, 1'b1, 32'h12345678);
        #1;
        check("dram_we", {31'd0, dram_we}, 32'h1);
        check("dram_addr", {18'd0, dram_addr}, 32'h4);
        check("dram_wdata", dram_wdata, 32'h12345678);
        tick();
        set_bus(32'h00000010, 1'b0, 32'h0);
        dram_rdata = 32'hCAFEBABE;
        #1;
        check("dram_we_idle", {31'd0, dram_we}, 32'h0);
        check("dram_rd", bus.Bus_rdata, 32'hCAFEBABE);

        // Switch synchronizer latency
        set_bus(32'hFFFFF070, 1'b0, 32'h0);
        sw = 24'h00F00F;
        #1;
        check("sw_rd_0", bus.Bus_rdata, 32'h0);
        tick();
        check("sw_rd_1", bus.Bus_rdata, 32'h0);
        tick();
        check("sw_rd_2", bus.Bus_rdata, 32'h0000F00F);
        set_bus(32'hFFFFF070, 1'b1, 32'hFFFFFFFF);
        tick();
        set_bus(32'hFFFFF070, 1'b0, 32'h0);
        #1;
        check("sw_wr_ignored", bus.Bus_rdata, 32'h0000F00F);

        btn = 5'h15;
        set_bus(32'hFFFFF078, 1'b0, 32'h0);
        tick();
        tick();
        check("btn_rd", bus.Bus_rdata, 32'h00000015);

        // Unmapped peripheral address
        set_bus(32'hFFFFF100, 1'b1, 32'hDEADBEEF);
        #1;
        check("unmapped_dram_we", {31'd0, dram_we}, 32'h0);
        tick();
        set_bus(32'hFFFFF100, 1'b0, 32'h0);
        #1;
        check("unmapped_rd", bus.Bus_rdata, 32'h0);

`ifdef BRIDGE_TIMER_EN
        set_bus(32'hFFFFF024, 1'b0, 32'h0);
        #1;
        check("tdiv_rst", bus.Bus_rdata, TDIV_RST);
        set_bus(32'hFFFFF024, 1'b1, 32'd0);
        tick();
        set_bus(32'hFFFFF020, 1'b1, 32'd0);
        tick();
        set_bus(32'hFFFFF024, 1'b1, 32'd3);
        tick();
        set_bus(32'hFFFFF020, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("tcnt_%0d", k + 1), bus.Bus_rdata, cnt_exp[k]);
        end
        // Ninth edge after the divider write is also an increment edge
        set_bus(32'hFFFFF020, 1'b1, 32'd100);
        tick();
        set_bus(32'hFFFFF020, 1'b0, 32'h0);
        #1;
        check("tcnt_collide", bus.Bus_rdata, 32'd100);
        tick();
        tick();
        check("tcnt_w11", bus.Bus_rdata, 32'd100);
        tick();
        check("tcnt_w12", bus.Bus_rdata, 32'd101);
        set_bus(32'hFFFFF024, 1'b1, 32'd0);
        tick();
        set_bus(32'hFFFFF020, 1'b0, 32'h0);
        repeat (10) tick();
        check("tcnt_frozen", bus.Bus_rdata, 32'd101);
`else
        set_bus(32'hFFFFF024, 1'b1, 32'd5);
        tick();
        set_bus(32'hFFFFF024, 1'b0, 32'h0);
        #1;
        check("tdiv_absent", bus.Bus_rdata, 32'h0);
        set_bus(32'hFFFFF020, 1'b0, 32'h0);
        #1;
        check("tcnt_absent", bus.Bus_rdata, 32'h0);
`endif

        // Asynchronous reset mid-scan with a write in flight
        set_bus(32'hFFFFF060, 1'b1, 32'h00FFFFFF);
        @(posedge cpu_clk);
        #2;
        cpu_rst = 1'b1;
        #1;
        check("arst_dig_en", {24'd0, dig_en}, 32'h0000_00FF);
        check("arst_seg", {24'd0, seg}, 32'h0000_00FF);
        check("arst_led", {8'd0, led}, 32'h0);
        tick();
        check("arst_led_hold", {8'd0, led}, 32'h0);
        set_bus(32'hFFFFF000, 1'b0, 32'h0);
        #1;
        check("arst_dig_rd", bus.Bus_rdata, 32'h0);
`ifdef BRIDGE_TIMER_EN
        set_bus(32'hFFFFF024, 1'b0, 32'h0);
        #1;
        check("arst_tdiv", bus.Bus_rdata, TDIV_RST);
`endif
        #2;
        cpu_rst = 1'b0;
        tick();
        check("post_rst_dig_en", {24'd0, dig_en}, 32'h0000_00FE);
        check("post_rst_seg", {24'd0, seg}, 32'h0000_00C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
